// File: rtl/common.sv
// Shared types for the multiply/divide unit.
package common;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } multdiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } multdiv_state_t;

    // 32-bit two's-complement negation
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/multdiv_unit_div_iter.sv
// Radix-2 restoring divider core: unsigned operands, one quotient bit per
// cycle MSB first. The dividend shift register doubles as the quotient.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,   // must stay stable while stepping
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_done       // high during the final step
);

    logic [31:0] r_q;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic [32:0] w_rem33;
    logic [32:0] w_diff;

    // Partial remainder is always below the divisor, so 33 bits suffice and
    // bit 32 of the difference is the borrow (restore) flag.
    assign w_rem33 = {r_rem, r_q[31]};
    assign w_diff  = w_rem33 - {1'b0, i_divisor};
    assign o_quot  = r_q;
    assign o_rem   = r_rem;
    assign o_done  = (r_cnt == 5'd0);

    // Load operands, then shift/subtract one bit per step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q   <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_q   <= i_dividend;
            r_rem <= '0;
            r_cnt <= 5'd31;
        end else if (i_step) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_q   <= {r_q[30:0], 1'b1};
            end else begin
                r_rem <= w_rem33[31:0];
                r_q   <= {r_q[30:0], 1'b0};
            end
            if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the Execute stage. ok low stalls E.
module multdiv_unit
    import common::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  multdiv_op_t op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        advance,
    input  logic        flush,
    output logic        ok,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    multdiv_state_t r_state, w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic        r_neg_q, r_neg_r;

    logic        w_signed, w_is_div, w_launch, w_div_done;
    logic [31:0] w_abs_a, w_abs_b, w_quot, w_rem, w_quot_fix, w_rem_fix;
    logic [63:0] w_prod, w_prod_fix;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_is_div = (op == MD_DIV)  || (op == MD_DIVU);
    assign w_launch = (r_state == ST_IDLE) && start && !flush;
    assign w_abs_a  = (w_signed && a[31]) ? neg32(a) : a;
    assign w_abs_b  = (w_signed && b[31]) ? neg32(b) : b;

    // Product of latched magnitudes; given MUL_CYCLES as a multicycle path
    assign w_prod     = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;

    // Quotient negated on sign mismatch, remainder follows dividend sign
    assign w_quot_fix = r_neg_q ? neg32(w_quot) : w_quot;
    assign w_rem_fix  = r_neg_r ? neg32(w_rem)  : w_rem;

    assign hi = r_hi;
    assign lo = r_lo;

    div_iter u_div (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_launch && w_is_div),
        .i_step     ((r_state == ST_DIV) && !flush),
        .i_dividend (w_abs_a),
        .i_divisor  (r_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_done     (w_div_done)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next state and ok; flush overrides everything
    always_comb begin
        w_next = r_state;
        ok     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ok = !start;
                if (start) w_next = w_is_div ? ST_DIV : ST_MUL;
            end
            ST_MUL:  if (r_cnt == 4'd0) w_next = ST_DONE;
            ST_DIV:  if (w_div_done)    w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: begin
                ok = 1'b1;
                if (advance) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (flush) begin
            w_next = ST_IDLE;
            ok     = 1'b1;
        end
    end

    // Operand capture at launch, multiply countdown, result write-back
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_launch) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg_q <= w_signed && (a[31] ^ b[31]);
            r_neg_r <= w_signed && a[31];
            if (!w_is_div) r_cnt <= 4'(MUL_CYCLES - 1);
        end else if (r_state == ST_MUL && !flush) begin
            if (r_cnt == 4'd0) {r_hi, r_lo} <= w_prod_fix;
            else               r_cnt <= r_cnt - 4'd1;
        end else if (r_state == ST_FIX && !flush) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized + directed bench for multdiv_unit against an arithmetic model.
module tb_multdiv_unit;
    import common::*;

    localparam int MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        resetn, start, advance, flush, ok;
    multdiv_op_t op;
    logic [31:0] a, b, hi, lo;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] prev;

    multdiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .advance(advance), .flush(flush), .ok(ok), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_md(input multdiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return {32'd0, x} * {32'd0, y};
            MD_DIVU: begin
                if (y == 0) begin q = 32'hFFFFFFFF; r = x; end
                else begin q = x / y; r = x % y; end
            end
            default: begin
                if (y == 0) begin q = x[31] ? 32'd1 : 32'hFFFFFFFF; r = x; end
                else begin q = 32'(sx / sy); r = 32'(sx % sy); end
            end
        endcase
        return {r, q};
    endfunction

    // Launch one op, hold start until done, optionally linger in DONE, then retire
    task automatic run_op(input string tag, input multdiv_op_t o, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        int lat, exp_lat;
        logic [63:0] exp;
        exp     = ref_md(o, x, y);
        exp_lat = (o == MD_DIV || o == MD_DIVU) ? 34 : MUL_CYCLES + 1;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; advance = 1'b0; flush = 1'b0;
        lat = 0;
        forever begin
            #1;
            if (ok) break;
            lat++;
            if (lat > 200) break;
            @(negedge clk);
            a = $urandom; b = $urandom;   // must not disturb captured operands
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_hilo"}, {hi, lo}, exp);
        repeat (hold) begin
            @(negedge clk);
            #1;
            chk({tag, "_hold_ok"}, 64'(ok), 64'd1);
            chk({tag, "_hold_hilo"}, {hi, lo}, exp);
        end
        advance = 1'b1;
        @(negedge clk);
        start = 1'b0; advance = 1'b0;
        #1;
        chk({tag, "_idle_ok"}, 64'(ok), 64'd1);
        chk({tag, "_idle_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; advance = 1'b0; flush = 1'b0;
        op = MD_MULT; a = '0; b = '0;
        #12;
        chk("rst_ok", 64'(ok), 64'd1);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_ok", 64'(ok), 64'd1);

        // Directed cases
        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("multu_max_val", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op("mult_neg", MD_MULT, -32'sd3, 32'd7, 0);
        chk("mult_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("div_neg", MD_DIV, -32'sd7, 32'd2, 0);
        chk("div_neg_val", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, 0);
        chk("divu_zero_val", {hi, lo}, 64'h00000064_FFFFFFFF);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("div_ovf_val", {hi, lo}, 64'h00000000_80000000);
        run_op("div_zero_neg", MD_DIV, -32'sd9, 32'd0, 0);
        run_op("divu_hold", MD_DIVU, 32'd17, 32'd5, 5);
        chk("divu_hold_val", {hi, lo}, 64'h00000002_00000003);

        // Flush in the start cycle: no launch, result untouched
        prev = {hi, lo};
        @(negedge clk);
        op = MD_DIV; a = 32'd50; b = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start_ok", 64'(ok), 64'd1);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_idle", 64'(ok), 64'd1);
        chk("flush_start_hilo", {hi, lo}, prev);

        // Flush at the 10th divide iteration
        @(negedge clk);
        op = MD_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_div_ok", 64'(ok), 64'd1);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush_div_idle", 64'(ok), 64'd1);
        chk("flush_div_hilo", {hi, lo}, prev);
        run_op("after_flush", MD_DIV, 32'd1000, -32'sd7, 0);

        // Randomized ops with a sprinkling of corner operands
        for (int i = 0; i < 40; i++) begin
            multdiv_op_t ro;
            logic [31:0] x, y;
            ro = multdiv_op_t'($urandom_range(0, 3));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
                3: y = $urandom_range(0, 5) - 2;
                default: ;
            endcase
            run_op("rand", ro, x, y, $urandom_range(0, 2));
        end

        // Asynchronous reset while in MUL
        @(negedge clk);
        op = MD_MULT; a = 32'd12345; b = 32'd678; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0; resetn = 1'b0;
        #1;
        chk("areset_ok", 64'(ok), 64'd1);
        chk("areset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("areset_idle_ok", 64'(ok), 64'd1);
        run_op("after_reset", MD_MULTU, 32'd12345, 32'd678, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
